// File: rtl/arbiter_1_to_n_response_engine.sv
// -----------------------------------------------------------------------------
// arbiter_1_to_n_response_engine
//
// This block takes the single merged response stream from the shared
// memory/engine port. It steers each packet by destination ID into one of
// NUM_ENGINE_RECEIVER per-consumer FIFOs. Each consumer pops on its own, so a
// slow consumer stalls the upstream only when its own FIFO nears full.
//
// Handshake: response_in_ready is a registered, credit-style permission. When
// upstream sees it high, it may present a beat in the next cycle. Every beat
// with response_in_valid high is taken: the block never refuses a valid beat.
// The almost-full level (PROG_THRESH) leaves at least 4 free entries. These
// absorb the beats already in flight when ready falls.
//
// Optional build macro: ARBITER_1_TO_N_DROP_COUNT_EN adds a saturating 32-bit
// drop_count. It counts packets whose id is out of range.
//
// Ports:
//   ap_clk                clock, all logic on rising edge
//   areset                asynchronous active-high reset
//   response_in_valid     upstream beat valid
//   response_in_id        destination consumer index
//   response_in_payload   beat data
//   response_in_ready     upstream may send next cycle (registered)
//   response_out_rd_en    per-consumer pop request
//   response_out_valid    per-consumer pop result valid (registered)
//   response_out_payload  packed per-consumer data, port k at [k*PW +: PW]
//   response_out_empty    per-consumer FIFO empty
//   fifo_setup_signal     high while the block is initialising
//   drop_count            (macro only) out-of-range packet count
// -----------------------------------------------------------------------------
module arbiter_1_to_n_response_engine #(
    parameter int NUM_ENGINE_RECEIVER = 2,
    parameter int ID_WIDTH            = (NUM_ENGINE_RECEIVER > 1) ? $clog2(NUM_ENGINE_RECEIVER) : 1,
    parameter int PAYLOAD_WIDTH       = 64,
    parameter int FIFO_DEPTH          = 16,
    parameter int PROG_THRESH         = 12
) (
    input  logic                                         ap_clk,
    input  logic                                         areset,
    input  logic                                         response_in_valid,
    input  logic [ID_WIDTH-1:0]                          response_in_id,
    input  logic [PAYLOAD_WIDTH-1:0]                     response_in_payload,
    output logic                                         response_in_ready,
    input  logic [NUM_ENGINE_RECEIVER-1:0]               response_out_rd_en,
    output logic [NUM_ENGINE_RECEIVER-1:0]               response_out_valid,
    output logic [NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH-1:0] response_out_payload,
    output logic [NUM_ENGINE_RECEIVER-1:0]               response_out_empty,
    output logic                                         fifo_setup_signal
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    ,
    output logic [31:0]                                  drop_count
`endif
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int IDX_WIDTH = ID_WIDTH + 1;

    // The id is zero-extended by one bit before the range check. Without this,
    // a power-of-two port count would not be representable in ID_WIDTH bits.
    localparam logic [IDX_WIDTH-1:0] NUM_PORTS  = IDX_WIDTH'(NUM_ENGINE_RECEIVER);
    localparam logic [CNT_WIDTH-1:0] DEPTH_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] THRESH     = CNT_WIDTH'(PROG_THRESH);

    // -------------------------------------------------------------------------
    // Reset release: asserted asynchronously, released through two flops.
    // init_sr[1] is the internal "still initialising" flag.
    // -------------------------------------------------------------------------
    logic [1:0] init_sr;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            init_sr <= 2'b11;
        end else begin
            init_sr <= {init_sr[0], 1'b0};
        end
    end

    assign fifo_setup_signal = init_sr[1];

    // -------------------------------------------------------------------------
    // Stage 1: unconditional input register
    // -------------------------------------------------------------------------
    logic                     s1_valid;
    logic [ID_WIDTH-1:0]      s1_id;
    logic [PAYLOAD_WIDTH-1:0] s1_payload;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_payload <= '0;
        end else begin
            s1_valid   <= response_in_valid & ~init_sr[1];
            s1_id      <= response_in_id;
            s1_payload <= response_in_payload;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: decode id into one write request per consumer FIFO
    // -------------------------------------------------------------------------
    logic                           in_range;
    logic [NUM_ENGINE_RECEIVER-1:0] wr_req;
    logic [NUM_ENGINE_RECEIVER-1:0] below_thresh;

    assign in_range = ({1'b0, s1_id} < NUM_PORTS);

    genvar g;
    for (g = 0; g < NUM_ENGINE_RECEIVER; g++) begin : g_fifo
        logic [PAYLOAD_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_WIDTH-1:0]     wr_ptr;
        logic [PTR_WIDTH-1:0]     rd_ptr;
        logic [CNT_WIDTH-1:0]     count;
        logic                     push;
        logic                     pop;
        logic                     out_valid;
        logic [PAYLOAD_WIDTH-1:0] out_data;

        assign wr_req[g] = s1_valid && in_range && (s1_id == ID_WIDTH'(g));

        // A pop on an empty FIFO is ignored.
        // A write to a full FIFO is dropped unless a pop frees a slot on the
        // same edge.
        assign pop  = response_out_rd_en[g] && (count != '0);
        assign push = wr_req[g] && ((count != DEPTH_FULL) || pop);

        always_ff @(posedge ap_clk or posedge areset) begin
            if (areset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_WIDTH'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_WIDTH'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_WIDTH'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_WIDTH'(1);
                end
            end
        end

        // Storage array has no reset; occupancy is tracked by count/pointers.
        always_ff @(posedge ap_clk) begin
            if (push) begin
                mem[wr_ptr] <= s1_payload;
            end
        end

        // One-cycle registered read. The data holds its last value when no
        // pop happens.
        always_ff @(posedge ap_clk or posedge areset) begin
            if (areset) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                out_valid <= pop;
                if (pop) begin
                    out_data <= mem[rd_ptr];
                end
            end
        end

        assign response_out_valid[g]                                     = out_valid;
        assign response_out_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]   = out_data;
        assign response_out_empty[g]                                     = (count == '0);
        assign below_thresh[g]                                           = (count < THRESH);
    end

    // -------------------------------------------------------------------------
    // Registered ready. It can first rise on the same edge where the setup
    // flag falls: init_sr[0] is already clear one edge before init_sr[1].
    // -------------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            response_in_ready <= 1'b0;
        end else begin
            response_in_ready <= ~init_sr[0] & (&below_thresh);
        end
    end

`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            drop_count <= '0;
        end else if (s1_valid && !in_range && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_1_to_n_response_engine.sv
// -----------------------------------------------------------------------------
// Testbench for arbiter_1_to_n_response_engine with 3 consumer ports.
// Port 3 does not exist, so id 3 exercises the out-of-range drop path.
// The reference model keeps one queue of expected payloads per port.
// Each entry carries the edge index from which it may be popped: a beat
// captured at edge e is poppable from edge e+2.
// -----------------------------------------------------------------------------
module tb_arbiter_1_to_n_response_engine;

  localparam int N      = 3;
  localparam int IDW    = 2;
  localparam int W      = 16;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;

  logic           ap_clk = 1'b0;
  logic           areset = 1'b1;
  logic           response_in_valid = 1'b0;
  logic [IDW-1:0] response_in_id = '0;
  logic [W-1:0]   response_in_payload = '0;
  logic           response_in_ready;
  logic [N-1:0]   response_out_rd_en = '0;
  logic [N-1:0]   response_out_valid;
  logic [N*W-1:0] response_out_payload;
  logic [N-1:0]   response_out_empty;
  logic           fifo_setup_signal;
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
  logic [31:0]    drop_count;
`endif

  arbiter_1_to_n_response_engine #(
    .NUM_ENGINE_RECEIVER(N),
    .ID_WIDTH(IDW),
    .PAYLOAD_WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .PROG_THRESH(THRESH)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .response_in_valid(response_in_valid),
    .response_in_id(response_in_id),
    .response_in_payload(response_in_payload),
    .response_in_ready(response_in_ready),
    .response_out_rd_en(response_out_rd_en),
    .response_out_valid(response_out_valid),
    .response_out_payload(response_out_payload),
    .response_out_empty(response_out_empty),
    .fifo_setup_signal(fifo_setup_signal)
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;  // index of the next rising edge, as seen at a falling edge
  always @(posedge ap_clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q   [N][$];
  int           avail_q [N][$];
  logic [N-1:0] pend_pop = '0;
  logic [W-1:0] pend_data [N];
  int           drops = 0;

  function automatic logic model_nonempty(input int k);
    return (exp_q[k].size() > 0) && (avail_q[k][0] <= cyc);
  endfunction

  function automatic logic [N-1:0] model_empty();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = ~model_nonempty(k);
    return e;
  endfunction

  // Drive one cycle at a falling edge, update the model, and return at the
  // next falling edge.
  task automatic drive_cycle(input logic v, input logic [IDW-1:0] id,
                             input logic [W-1:0] pl, input logic [N-1:0] rd);
    response_in_valid   = v;
    response_in_id      = id;
    response_in_payload = pl;
    response_out_rd_en  = rd;
    for (int k = 0; k < N; k++) begin
      pend_pop[k] = 1'b0;
      if (rd[k] && model_nonempty(k)) begin
        pend_pop[k]  = 1'b1;
        pend_data[k] = exp_q[k].pop_front();
        void'(avail_q[k].pop_front());
      end
    end
    if (v) begin
      if (int'(id) < N) begin
        exp_q[int'(id)].push_back(pl);
        avail_q[int'(id)].push_back(cyc + 2);
      end else begin
        drops++;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      avail_q[k].delete();
    end
    pend_pop = '0;
    drops    = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge ap_clk);
    n_checks++; if (fifo_setup_signal !== 1'b1) begin n_fail++; $display("FAIL reset_setup: got %b need 1", fifo_setup_signal); end
    n_checks++; if (response_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", response_in_ready); end
    n_checks++; if (response_out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b need 000", response_out_valid); end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL reset_empty: got %b need 111", response_out_empty); end
    n_checks++; if (response_out_payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %h need 0", response_out_payload); end
    areset = 1'b0;
    @(negedge ap_clk);
    n_checks++; if (fifo_setup_signal !== 1'b1) begin n_fail++; $display("FAIL release1_setup: got %b need 1", fifo_setup_signal); end
    n_checks++; if (response_in_ready !== 1'b0) begin n_fail++; $display("FAIL release1_ready: got %b need 0", response_in_ready); end
    @(negedge ap_clk);
    n_checks++; if (fifo_setup_signal !== 1'b0) begin n_fail++; $display("FAIL release2_setup: got %b need 0", fifo_setup_signal); end
    n_checks++; if (response_in_ready !== 1'b1) begin n_fail++; $display("FAIL release2_ready: got %b need 1", response_in_ready); end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL release2_empty: got %b need 111", response_out_empty); end
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    n_checks++; if (drop_count !== 32'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d need 0", drop_count); end
`endif
  endtask

  task automatic test_steering();
    drive_cycle(1'b1, 2'd2, 16'h000A, 3'b000);
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL steer_latency1: got %b need 111", response_out_empty); end
    drive_cycle(1'b1, 2'd0, 16'h000B, 3'b000);
    n_checks++; if (response_out_empty !== 3'b011) begin n_fail++; $display("FAIL steer_latency2: got %b need 011", response_out_empty); end
    drive_cycle(1'b1, 2'd2, 16'h000C, 3'b000);
    n_checks++; if (response_out_empty !== 3'b010) begin n_fail++; $display("FAIL steer_empty3: got %b need 010", response_out_empty); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
    n_checks++; if (response_out_empty !== 3'b010) begin n_fail++; $display("FAIL steer_empty4: got %b need 010", response_out_empty); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b100);
    n_checks++; if (response_out_valid !== 3'b100) begin n_fail++; $display("FAIL steer_pop1_valid: got %b need 100", response_out_valid); end
    n_checks++; if (response_out_payload[2*W +: W] !== 16'h000A) begin n_fail++; $display("FAIL steer_pop1_data: got %h need 000a", response_out_payload[2*W +: W]); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b100);
    n_checks++; if (response_out_valid !== 3'b100) begin n_fail++; $display("FAIL steer_pop2_valid: got %b need 100", response_out_valid); end
    n_checks++; if (response_out_payload[2*W +: W] !== 16'h000C) begin n_fail++; $display("FAIL steer_pop2_data: got %h need 000c", response_out_payload[2*W +: W]); end
    n_checks++; if (response_out_empty !== 3'b110) begin n_fail++; $display("FAIL steer_port0_holds: got %b need 110", response_out_empty); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b001);
    n_checks++; if (response_out_valid !== 3'b001) begin n_fail++; $display("FAIL steer_pop0_valid: got %b need 001", response_out_valid); end
    n_checks++; if (response_out_payload[0 +: W] !== 16'h000B) begin n_fail++; $display("FAIL steer_pop0_data: got %h need 000b", response_out_payload[0 +: W]); end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL steer_final_empty: got %b need 111", response_out_empty); end
  endtask

  task automatic test_simul_push_pop();
    drive_cycle(1'b1, 2'd0, 16'h0011, 3'b000);
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
    n_checks++; if (response_out_empty !== 3'b110) begin n_fail++; $display("FAIL simul_one_entry: got %b need 110", response_out_empty); end
    drive_cycle(1'b1, 2'd0, 16'h0022, 3'b000);
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b001);   // pop and write hit the same edge
    n_checks++; if (response_out_valid !== 3'b001) begin n_fail++; $display("FAIL simul_valid: got %b need 001", response_out_valid); end
    n_checks++; if (response_out_payload[0 +: W] !== 16'h0011) begin n_fail++; $display("FAIL simul_old_head: got %h need 0011", response_out_payload[0 +: W]); end
    n_checks++; if (response_out_empty !== 3'b110) begin n_fail++; $display("FAIL simul_count_kept: got %b need 110", response_out_empty); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b001);
    n_checks++; if (response_out_valid !== 3'b001) begin n_fail++; $display("FAIL simul_second_valid: got %b need 001", response_out_valid); end
    n_checks++; if (response_out_payload[0 +: W] !== 16'h0022) begin n_fail++; $display("FAIL simul_new_pkt: got %h need 0022", response_out_payload[0 +: W]); end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b001);   // pop on empty is ignored
    n_checks++; if (response_out_valid !== 3'b000) begin n_fail++; $display("FAIL underflow_valid: got %b need 000", response_out_valid); end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL underflow_empty: got %b need 111", response_out_empty); end
  endtask

  task automatic test_out_of_range();
    drive_cycle(1'b1, 2'd3, 16'hDEAD, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
      n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL oor_no_write: got %b need 111", response_out_empty); end
    end
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    n_checks++; if (drop_count !== 32'(drops)) begin n_fail++; $display("FAIL oor_drop_count: got %0d need %0d", drop_count, drops); end
`endif
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    logic low_seen = 1'b0;
    for (int i = 0; i < 40 && !low_seen; i++) begin
      if (response_in_ready) begin
        drive_cycle(1'b1, 2'd1, W'($urandom), 3'b000);
        sent++;
      end else begin
        low_seen = 1'b1;
      end
    end
    n_checks++; if (!low_seen) begin n_fail++; $display("FAIL bp_ready_fall: got ready still high after %0d beats need low", sent); end
    n_checks++; if (sent < THRESH || sent > DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d beats need %0d..%0d", sent, THRESH, DEPTH); end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
    n_checks++; if (response_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b need 0", response_in_ready); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_cycle(1'b0, 2'd0, 16'h0000, 3'b010);
      n_checks++; if (response_out_valid[1] !== pend_pop[1]) begin n_fail++; $display("FAIL bp_drain_valid[%0d]: got %b need %b", i, response_out_valid[1], pend_pop[1]); end
      if (pend_pop[1]) begin
        n_checks++; if (response_out_payload[W +: W] !== pend_data[1]) begin n_fail++; $display("FAIL bp_drain_data[%0d]: got %h need %h", i, response_out_payload[W +: W], pend_data[1]); end
      end
    end
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL bp_drained_empty: got %b need 111", response_out_empty); end
    n_checks++; if (response_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b need 1", response_in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 424; i++) begin
      logic         v;
      logic [N-1:0] rd;
      for (int k = 0; k < N; k++) begin
        n_checks++; if (response_out_valid[k] !== pend_pop[k]) begin n_fail++; $display("FAIL rand_valid[%0d] port %0d: got %b need %b", i, k, response_out_valid[k], pend_pop[k]); end
        if (pend_pop[k]) begin
          n_checks++; if (response_out_payload[k*W +: W] !== pend_data[k]) begin n_fail++; $display("FAIL rand_data[%0d] port %0d: got %h need %h", i, k, response_out_payload[k*W +: W], pend_data[k]); end
        end
      end
      n_checks++; if (response_out_empty !== model_empty()) begin n_fail++; $display("FAIL rand_empty[%0d]: got %b need %b", i, response_out_empty, model_empty()); end
      // The last 24 cycles only pop, so every port drains.
      v  = (i < 400) && response_in_ready && ($urandom_range(0, 3) != 0);
      rd = (i < 400) ? N'($urandom) : 3'b111;
      drive_cycle(v, IDW'($urandom_range(0, 3)), W'($urandom), rd);
    end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL rand_final_empty: got %b need 111", response_out_empty); end
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    n_checks++; if (drop_count !== 32'(drops)) begin n_fail++; $display("FAIL rand_drop_count: got %0d need %0d", drop_count, drops); end
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 2'd1, W'(16'h0100 + i), 3'b000);
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b000);
    drive_cycle(1'b0, 2'd0, 16'h0000, 3'b010);
    n_checks++; if (response_out_valid !== 3'b010) begin n_fail++; $display("FAIL mid_pre_valid: got %b need 010", response_out_valid); end
    areset = 1'b1;
    response_out_rd_en = '0;
    clear_model();
    #1;
    n_checks++; if (response_out_valid !== 3'b000) begin n_fail++; $display("FAIL mid_valid: got %b need 000", response_out_valid); end
    n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL mid_empty: got %b need 111", response_out_empty); end
    n_checks++; if (response_out_payload !== '0) begin n_fail++; $display("FAIL mid_payload: got %h need 0", response_out_payload); end
    n_checks++; if (fifo_setup_signal !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got %b need 1", fifo_setup_signal); end
    n_checks++; if (response_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b need 0", response_in_ready); end
    @(negedge ap_clk);
    areset = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    n_checks++; if (fifo_setup_signal !== 1'b0) begin n_fail++; $display("FAIL mid_release_setup: got %b need 0", fifo_setup_signal); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 2'd0, 16'h0000, 3'b111);
      n_checks++; if (response_out_valid !== 3'b000) begin n_fail++; $display("FAIL mid_stale_valid: got %b need 000", response_out_valid); end
      n_checks++; if (response_out_empty !== 3'b111) begin n_fail++; $display("FAIL mid_stale_empty: got %b need 111", response_out_empty); end
    end
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    n_checks++; if (drop_count !== 32'd0) begin n_fail++; $display("FAIL mid_drop_count: got %0d need 0", drop_count); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_steering();
    test_simul_push_pop();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_1_to_n_response_engine.md
Name: arbiter_1_to_N_response_engine

Overview:
Downstream counterpart of the N-to-1 request arbiter. Takes the single merged response stream returning from the shared memory/engine port and steers each packet to one of N engine consumers by destination ID. Each consumer has its own small buffering FIFO and pops independently, so one slow consumer does not block the others until its FIFO nears full. Upstream backpressure is a registered credit-style ready.

Parameters:
NUM_ENGINE_RECEIVER, 2, number of consumer ports (1..16)
ID_WIDTH, $clog2(NUM_ENGINE_RECEIVER) min 1, width of destination ID field
PAYLOAD_WIDTH, 64, width of packet payload
FIFO_DEPTH, 16, per-consumer FIFO depth (power of 2, >=8)
PROG_THRESH, 12, per-consumer almost-full level; must be <= FIFO_DEPTH-4

Ports:
ap_clk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous active-high reset
response_in_valid  in  1  upstream packet valid
response_in_id  in  ID_WIDTH  destination consumer index
response_in_payload  in  PAYLOAD_WIDTH  packet data
response_in_ready  out  1  upstream may send next cycle (registered)
response_out_rd_en  in  NUM_ENGINE_RECEIVER  per-consumer pop request
response_out_valid  out  NUM_ENGINE_RECEIVER  per-consumer output valid (registered)
response_out_payload  out  NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH  packed per-consumer data, port k at [k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
response_out_empty  out  NUM_ENGINE_RECEIVER  per-consumer FIFO empty
fifo_setup_signal  out  1  high while block is initialising

Behaviour:
- Reset (async assert, sync-released internally via 2-flop stage): all FIFOs empty, response_in_ready=0, response_out_valid=0, response_out_payload=0, response_out_empty=all 1, fifo_setup_signal=1. Payload regs also cleared.
- fifo_setup_signal drops 2 cycles after areset deasserts; response_in_ready may rise the same cycle, not earlier.
- Stage 1: input register captures valid/id/payload every cycle. Valid is a fire: the block never refuses a valid beat; upstream must honour ready.
- Stage 2: decode id; if id < NUM_ENGINE_RECEIVER, write payload into FIFO[id] at next edge. Packet at input edge t is in FIFO after edge t+1; response_out_empty[id] low from cycle t+2.
- id >= NUM_ENGINE_RECEIVER (non-power-of-2 N): packet dropped, no FIFO written.
- response_in_ready = registered AND over all k of (count[k] < PROG_THRESH). Slack of 4 entries covers the 3 beats in flight after ready falls; a FIFO never overflows under legal upstream.
- Pop: rd_en[k] at edge t with FIFO[k] non-empty -> response_out_valid[k]=1 and payload at t+1 (one-cycle registered read), valid low otherwise. rd_en on empty FIFO ignored, no underflow, count unchanged.
- Simultaneous write and pop on same FIFO: count unchanged, both take effect; write to full FIFO (protocol violation) is discarded, count saturates.
- Per-FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Per-port order preserved; no ordering between ports.
- Reset asserted mid-traffic: all in-flight and buffered packets lost, outputs return to reset values immediately.

Optional Feature:
ARBITER_1_TO_N_DROP_COUNT_EN: when defined, adds output drop_count (32 bits) counting packets dropped for out-of-range id, saturating at 0xFFFFFFFF, cleared by areset. When undefined, the port and counter are absent and drops are silent.

Test Plan:
- Reset release: areset low at cycle 0 -> fifo_setup_signal low and response_in_ready high at cycle 2, all response_out_empty=1.
- Steering: N=4, send ids 2,0,2 payloads 0xA,0xB,0xC back-to-back, pop port 2 twice -> port 2 outputs 0xA then 0xC, port 0 holds 0xB, ports 1,3 stay empty.
- Backpressure: N=2, no pops, stream to id 1 continuously -> response_in_ready falls after count[1] reaches 12; FIFO[1] ends at <=16 entries, none lost, draining 16 pops returns payloads in order.
- Simultaneous push/pop: FIFO[0] holds 1 entry, write and rd_en same edge -> count stays 1, output shows old head, next pop yields new packet.
- Out-of-range: N=3, send id 3 -> no FIFO written; with ARBITER_1_TO_N_DROP_COUNT_EN drop_count goes 0->1.
- Mid-traffic reset: assert areset with 5 entries buffered -> response_out_valid=0 and all empty in the same cycle, no stale packet after release.
